seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Multi-cycle unsigned shift-add multiplier in the ALU datapath. Its low product word drives one data input of the 8-to-1 32-bit ALU result selector. The upper word is available for a HI register. It uses a start/done handshake so the ALU controller holds the result select until the product is valid.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits, split into lo/hi words.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
a  input  WIDTH  multiplicand; captured on accepted start
b  input  WIDTH  multiplier; captured on accepted start
busy  output  1  high while the iteration is in progress
done  output  1  one-cycle pulse: product valid
product_lo  output  WIDTH  low product word, feeds the ALU result selector
product_hi  output  WIDTH  high product word

Behaviour:
- The reset is asynchronous and active-low (rst_n); there is one clock (clk).
- Reset values: state=IDLE, busy=0, done=0, product_lo=0, product_hi=0, internal multiplicand=0, iteration counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture a into the multiplicand register. Load product register {hi=0, lo=b}. Clear the counter and go to RUN. Otherwise stay in IDLE.
- RUN, per cycle:
  - If lo[0]=1, the sum is hi + multiplicand as (WIDTH+1) bits, keeping the carry; otherwise the sum is hi with carry 0.
  - {carry, sum, lo} shifts right by 1 into {hi, lo}.
  - counter increments.
  - After the WIDTH-th RUN cycle (counter = WIDTH-1 at that edge), go to DONE.
- DONE: done=1 for exactly this one cycle.
  - start=1 here is accepted: reload operands and go to RUN. There is no dead cycle for back-to-back operations.
  - Otherwise go to IDLE.
- busy=1 exactly in RUN. It is 0 in IDLE and DONE.
- Latency: with start accepted at clock edge N, done is high in the cycle after edge N+WIDTH. That is WIDTH+1 edges from start to the done pulse (33 for WIDTH=32).
- start while busy is ignored. Operand changes during RUN have no effect.
- During RUN, product_lo/product_hi show intermediate partial values. Consumers use them only in the done cycle or afterwards.
- After DONE, product_lo/product_hi hold their value in IDLE until the next accepted start. The next accepted start overwrites them on its capture edge.
- Arithmetic: unsigned only, full 2*WIDTH-bit result, no overflow flag. The carry bit is mandatory so that all-ones operands give the exact result.
- rst_n low at any time, including mid-RUN: everything returns to reset values immediately. There is no done pulse for the aborted operation. After release, the block waits in IDLE for a new start.
- Zero operands still take the full WIDTH cycles. There is no early termination.

Decomposition:
- Shared ALU package:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default WIDTH
  - the ALU select code under which the result selector routes product_lo
- Sub-module seq_mult_datapath: the multiplicand register, the {hi,lo} product register, the (WIDTH+1)-bit adder and the shift logic. It is controlled by load/step strobes from the FSM in seq_multiplier, which also owns the counter and handshake.

Test Plan:
- a=3, b=5, start for 1 cycle -> busy for 32 cycles; done pulses once on edge 33; product_hi=0, product_lo=15.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001 (checks the carry).
- a=0x12345678, b=0 and a=0, b=0x9ABCDEF0 -> product 0; latency still 33; done is one cycle wide.
- Start a=7, b=6; during RUN pulse start with a=2, b=2 and change a/b every cycle -> the pulses are ignored; result 42; exactly one done.
- Back-to-back: start held high through DONE with a=10, b=10 -> second run begins with no gap; result 100; done pulses 33 edges apart.
- rst_n low at RUN cycle 15, then released -> all outputs 0 asynchronously; no done; next start with a=9, b=9 gives 81.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared ALU definitions: multiplier FSM encoding, default operand width and
// the result-selector code that routes the low product word.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // ALU result selector input carrying product_lo
    localparam logic [2:0] ALU_SEL_MUL = 3'd5;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: multiplicand register, {hi,lo} product register and the
// carry-preserving (WIDTH+1)-bit adder, driven by load/step strobes.
module seq_mult_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH:0]   sum_s;

    // Partial sum; the extra bit keeps the carry so all-ones operands stay exact
    always_comb begin
        sum_s = {1'b0, hi_r};
        if (lo_r[0]) begin
            sum_s = {1'b0, hi_r} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, hi_r};
        end
    end

    // Operand capture on load, {carry,sum,lo} >> 1 on each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else if (load) begin
            mcand_r <= a;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= b;
        end else if (step) begin
            hi_r    <= sum_s[WIDTH:1];
            lo_r    <= {sum_s[0], lo_r[WIDTH-1:1]};
        end else begin
            mcand_r <= mcand_r;
            hi_r    <= hi_r;
            lo_r    <= lo_r;
        end
    end

    assign prod_lo = lo_r;
    assign prod_hi = hi_r;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier with start/busy/done handshake.
// The FSM owns the iteration counter; a DONE-cycle start restarts with no gap.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mult_state_t   state_r;
    mult_state_t   state_next_s;
    logic [CW-1:0] cnt_r;
    logic          load_s;
    logic          step_s;
    logic          busy_r;
    logic          done_r;

    // Next-state and datapath strobe decode
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, iteration counter and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
            if (load_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (step_s) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .step    (step_s),
        .a       (a),
        .b       (b),
        .prod_lo (product_lo),
        .prod_hi (product_hi)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: table of operand/product vectors plus
// hand-written sequences for ignored starts, back-to-back runs and reset abort.
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] product_lo;
    logic [W-1:0] product_hi;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Start one operation and wait for done; returns edges from capture (inclusive)
    // to the edge after which done is high, and the number of busy samples seen.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        if (busy) busy_cnt++;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        vec_t vecs[8];
        int lat;
        int bc;
        int dones;
        int d1;
        int d2;

        vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h1234_5678,  32'h0000_0000,  32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h0000_0000,  32'h9ABC_DEF0,  32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000, 32'hFFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF,  32'h0000_0002,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{32'h8000_0000,  32'h8000_0001,  32'h4000_0000, 32'h8000_0000};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, lat, bc);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd32);
            check($sformatf("vec%0d_product", i), {product_hi, product_lo},
                  {vecs[i].exp_hi, vecs[i].exp_lo});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_width", i), {63'd0, done}, 64'd0);
            check($sformatf("vec%0d_hold", i), {product_hi, product_lo},
                  {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Starts and operand changes while busy are ignored
        @(negedge clk);
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 45; c++) begin
            a = $urandom;
            b = $urandom;
            start = (c == 3 || c == 10 || c == 20) ? 1'b1 : 1'b0;
            if (c == 3) begin
                a = 32'd2;
                b = 32'd2;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                check("ignore_product", {product_hi, product_lo}, 64'd42);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_done_count", 64'(dones), 64'd1);
        check("ignore_hold_idle", {product_hi, product_lo}, 64'd42);

        // Back-to-back: start held through DONE restarts with no gap
        @(negedge clk);
        a = 32'd10;
        b = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        d1 = -1;
        d2 = -1;
        for (int e = 1; e < 100 && d2 < 0; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("b2b_product", {product_hi, product_lo}, 64'd100);
                if (d1 < 0) d1 = e;
                else d2 = e;
            end
        end
        start = 1'b0;
        check("b2b_first_done", 64'(d1), 64'd32);
        check("b2b_spacing", 64'(d2 - d1), 64'd33);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        a = 32'd5;
        b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op(32'd9, 32'd9, lat, bc);
        check("after_abort_latency", 64'(lat), 64'd33);
        check("after_abort_product", {product_hi, product_lo}, 64'd81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
